// File: rtl/jtcommando_rom_sched.sv
// ROM read scheduler: one-entry cache per client, round-robin miss service on
// the shared SDRAM read port, refresh gating and download/loop_rst blocking.
module jtcommando_rom_slot #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          ok,
  output logic [DW-1:0] dout
);
  logic          valid;
  logic [AW-1:0] cache_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      cache_addr <= '0;
      dout       <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (we) begin
      valid      <= 1'b1;
      cache_addr <= waddr;
      dout       <= wdata;
    end
  end

  assign ok = cs & valid & (cache_addr == addr);
endmodule

module jtcommando_rom_sched #(
  parameter int SLOTS = 5,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, LATCH} state_t;

  state_t           state;
  logic [IW-1:0]    sel, rr, pick;
  logic             discard, blocked, fill;
  logic [SLOTS-1:0] miss, we;
  logic [AW-1:0]    addr_a [SLOTS];

  // First miss found scanning rr, rr+1, ... modulo SLOTS.
  function automatic logic [IW-1:0] rr_pick(input logic [SLOTS-1:0] m, input logic [IW-1:0] p);
    int idx;
    rr_pick = p;
    for (int k = SLOTS-1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (m[idx]) rr_pick = IW'(idx);
    end
  endfunction

  assign blocked = downloading | loop_rst;
  assign miss    = slot_cs & ~slot_ok;
  assign pick    = rr_pick(miss, rr);
  assign fill    = (state == WAIT) & data_rdy & ~discard & ~blocked;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_a[i] = slot_addr[i*AW +: AW];
    assign we[i]     = fill & (sel == IW'(i));
    jtcommando_rom_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (blocked),
      .we    (we[i]),
      .cs    (slot_cs[i]),
      .addr  (addr_a[i]),
      .waddr (sdram_addr),
      .wdata (data_read),
      .ok    (slot_ok[i]),
      .dout  (slot_dout[i*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      rr         <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      refresh_en <= 1'b0;
      discard    <= 1'b0;
    end else begin
      refresh_en <= (state == IDLE) & ~(|miss) & ~blocked;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (!blocked && |miss) begin
            sel        <= pick;
            sdram_addr <= addr_a[pick];
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // A block before the ack withdraws the request; after it, the read
          // still has to drain but its data is thrown away.
          if (blocked) begin
            sdram_req <= 1'b0;
            discard   <= 1'b1;
            state     <= sdram_ack ? WAIT : IDLE;
          end else if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (blocked) discard <= 1'b1;
          if (data_rdy) state <= LATCH;
        end
        LATCH: begin
          rr    <= (sel == IW'(SLOTS-1)) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtcommando_rom_sched.sv
// Directed bench for jtcommando_rom_sched: cache hits, round-robin order,
// address change mid-fetch, download blocking and reset mid-request.
module tb_jtcommando_rom_sched;
  localparam int SLOTS = 5;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst_n, downloading, loop_rst;
  logic [SLOTS-1:0]    slot_cs, slot_ok;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req, sdram_ack, data_rdy, refresh_en;
  logic [AW-1:0]       sdram_addr;
  logic [DW-1:0]       data_read;

  int nv = 0;
  int nerr = 0;

  jtcommando_rom_sched #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nv++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete fetch from IDLE with a miss pending: grant, ack, data, latch.
  task automatic serve(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    chk({tag, "_req"}, 192'(sdram_req), 192'd1);
    chk({tag, "_addr"}, 192'(sdram_addr), 192'(a));
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    data_rdy = 1'b1;
    data_read = d;
    step();
    data_rdy = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
    slot_cs = '0; slot_addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    step(); step();
    chk("rst_req", 192'(sdram_req), 192'd0);
    chk("rst_refresh", 192'(refresh_en), 192'd0);
    chk("rst_dout", 192'(slot_dout), 192'd0);
    rst_n = 1'b1;
    step();
    chk("idle_refresh", 192'(refresh_en), 192'd1);
    chk("idle_req", 192'(sdram_req), 192'd0);
    chk("idle_ok", 192'(slot_ok), 192'd0);

    // Single miss on slot 2
    slot_cs = 5'b00100;
    slot_addr[2*AW +: AW] = 22'h01234;
    step();
    chk("s2_req", 192'(sdram_req), 192'd1);
    chk("s2_addr", 192'(sdram_addr), 192'h01234);
    chk("s2_refresh", 192'(refresh_en), 192'd0);
    step();
    chk("s2_req_hold", 192'(sdram_req), 192'd1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk("s2_req_drop", 192'(sdram_req), 192'd0);
    step();
    data_rdy = 1'b1; data_read = 32'hDEADBEEF;
    step();
    data_rdy = 1'b0;
    chk("s2_ok_latch", 192'(slot_ok), 192'b00100);
    chk("s2_dout", 192'(slot_dout[2*DW +: DW]), 192'hDEADBEEF);
    step(); step();
    chk("s2_hit_noreq", 192'(sdram_req), 192'd0);
    chk("s2_hit_refresh", 192'(refresh_en), 192'd1);

    // Round robin from rr=0: slots 0,1,4
    rst_n = 1'b0; slot_cs = '0;
    step();
    rst_n = 1'b1;
    slot_addr[0*AW +: AW] = 22'h100;
    slot_addr[1*AW +: AW] = 22'h200;
    slot_addr[4*AW +: AW] = 22'h400;
    slot_cs = 5'b10011;
    serve("rr0_a", 22'h100, 32'h11110100);
    serve("rr0_b", 22'h200, 32'h22220200);
    serve("rr0_c", 22'h400, 32'h44440400);
    chk("rr0_ok", 192'(slot_ok), 192'b10011);
    chk("rr0_dout4", 192'(slot_dout[4*DW +: DW]), 192'h44440400);
    slot_addr[1*AW +: AW] = 22'h204;
    serve("rr_to2", 22'h204, 32'h22220204);
    // rr=2 now: slots 0 and 4 miss, 4 goes first
    slot_addr[0*AW +: AW] = 22'h108;
    slot_addr[4*AW +: AW] = 22'h408;
    serve("rr2_a", 22'h408, 32'h44440408);
    serve("rr2_b", 22'h108, 32'h11110108);
    chk("rr2_ok", 192'(slot_ok), 192'b10011);
    chk("rr2_dout0", 192'(slot_dout[0 +: DW]), 192'h11110108);

    // Address change during WAIT
    slot_cs = 5'b00001;
    slot_addr[0*AW +: AW] = 22'h100;
    step();
    chk("chg_addr", 192'(sdram_addr), 192'h100);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    slot_addr[0*AW +: AW] = 22'h104;
    data_rdy = 1'b1; data_read = 32'hAAAA0100;
    step();
    data_rdy = 1'b0;
    chk("chg_ok", 192'(slot_ok), 192'd0);
    chk("chg_dout", 192'(slot_dout[0 +: DW]), 192'hAAAA0100);
    step();
    serve("chg_refetch", 22'h104, 32'hAAAA0104);
    chk("chg_ok2", 192'(slot_ok), 192'b00001);

    // Downloading during WAIT
    slot_cs = 5'b10011;
    slot_addr[0*AW +: AW] = 22'h300;
    step();
    chk("dl_addr", 192'(sdram_addr), 192'h300);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    downloading = 1'b1;
    step();
    chk("dl_ok_clr", 192'(slot_ok), 192'd0);
    data_rdy = 1'b1; data_read = 32'h00000055;
    step();
    data_rdy = 1'b0;
    chk("dl_ok_rdy", 192'(slot_ok), 192'd0);
    chk("dl_dout_kept", 192'(slot_dout[0 +: DW]), 192'hAAAA0104);
    step(); step(); step();
    chk("dl_noreq", 192'(sdram_req), 192'd0);
    chk("dl_norefresh", 192'(refresh_en), 192'd0);
    downloading = 1'b0;
    step();
    chk("dl_post_req", 192'(sdram_req), 192'd1);
    chk("dl_post_addr", 192'(sdram_addr), 192'h204);

    // Reset during REQ, then a stray data_rdy
    rst_n = 1'b0; slot_cs = '0;
    step();
    rst_n = 1'b1;
    chk("rreq_req", 192'(sdram_req), 192'd0);
    chk("rreq_addr", 192'(sdram_addr), 192'd0);
    data_rdy = 1'b1; data_read = 32'hBADBAD00;
    step();
    data_rdy = 1'b0;
    slot_cs = 5'b10011;
    #1;
    chk("rreq_ok", 192'(slot_ok), 192'd0);
    chk("rreq_dout", 192'(slot_dout), 192'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
